// File: rtl/sweep_controller_pkg.sv
// Shared definitions for the frequency-sweep controller.
//   ROM_PHASE_BIT / DAC_MAX_V_BIT : system widths from which the default
//                                   tuning-word and amplitude widths derive.
//   sweep_mode_e  : sweep mode encodings carried on the 2-bit mode port.
//   sweep_state_e : controller FSM states.
//   sweep_dir_e   : current sweep direction.
package sweep_controller_pkg;

  localparam int unsigned ROM_PHASE_BIT = 16;
  localparam int unsigned DAC_MAX_V_BIT = 13;

  typedef enum logic [1:0] {
    SWEEP_MODE_ONCE_UP   = 2'b00,
    SWEEP_MODE_REPEAT_UP = 2'b01,
    SWEEP_MODE_TRIANGLE  = 2'b10,
    SWEEP_MODE_HOLD      = 2'b11
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } sweep_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } sweep_dir_e;

endpackage

// File: rtl/sweep_controller_dwell_timer.sv
// Dwell timer: counts how long the current tuning word has been held.
//   clk, rst  : clock, synchronous active-high reset
//   load      : restart the dwell with load_val cycles (load_val >= 1)
//   load_val  : dwell length in cycles
//   en        : count enable (controller in RUN)
//   expire    : high during the last cycle of the dwell while enabled
module dwell_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt;

  // cnt holds the number of cycles remaining after the current one, so a
  // dwell of D loaded on a cycle edge expires during the D-th cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/sweep_controller.sv
// Frequency-sweep controller: steps the phase increment of a DDS between
// two bounds, holding each value for a programmable dwell.
//   clk, rst         : 1 MHz clock, synchronous active-high reset
//   start, stop      : one-cycle sweep request / abort
//   mode             : 00 once-up, 01 repeat-up, 10 triangle, 11 hold
//   m_start/m_stop/m_step : sweep bounds and increment
//   dwell            : cycles each tuning word is held (0 treated as 1)
//   amp_in, shape_in : amplitude code and waveform select, latched at start
//   phase_M          : tuning word to the phase accumulator
//   signal_A         : amplitude to the amplitude control stage
//   signal_shape     : shape select to the phase-to-amplitude stage
//   upd              : strobe on every new phase_M value
//   busy             : high in RUN, HOLD and DONE
//   done             : one-cycle pulse at normal completion
module sweep_controller
  import sweep_controller_pkg::*;
#(
  parameter int unsigned M_W     = ROM_PHASE_BIT - 1,
  parameter int unsigned A_W     = DAC_MAX_V_BIT - 1,
  parameter int unsigned DWELL_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [M_W-1:0]     m_start,
  input  logic [M_W-1:0]     m_stop,
  input  logic [M_W-1:0]     m_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [A_W-1:0]     amp_in,
  input  logic [1:0]         shape_in,
  output logic [M_W-1:0]     phase_M,
  output logic [A_W-1:0]     signal_A,
  output logic [1:0]         signal_shape,
  output logic               upd,
  output logic               busy,
  output logic               done
);

  sweep_state_e       state;
  sweep_mode_e        mode_q;
  sweep_dir_e         dir_q;
  logic [M_W-1:0]     start_q;
  logic [M_W-1:0]     stop_q;
  logic [M_W-1:0]     step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               degen_q;

  logic [DWELL_W-1:0] dwell_in_eff;
  logic               launch;
  logic               expire;
  logic               reload;
  logic [DWELL_W-1:0] reload_val;

  logic [M_W:0]       up_sum;
  logic [M_W:0]       down_floor;
  logic [M_W-1:0]     up_next;
  logic [M_W-1:0]     down_next;
  logic [M_W-1:0]     next_phase;
  sweep_dir_e         next_dir;
  logic               finish;

  assign dwell_in_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign launch       = (state == ST_IDLE) && start && !stop;

  // Step arithmetic is one bit wider so clamping happens before any wrap.
  assign up_sum     = {1'b0, phase_M} + {1'b0, step_q};
  assign down_floor = {1'b0, start_q} + {1'b0, step_q};
  assign up_next    = (up_sum >= {1'b0, stop_q}) ? stop_q : up_sum[M_W-1:0];
  assign down_next  = ({1'b0, phase_M} <= down_floor) ? start_q : (phase_M - step_q);

  // Decision taken at dwell expiry in RUN.
  always_comb begin
    finish     = 1'b0;
    next_dir   = dir_q;
    next_phase = phase_M;
    if (degen_q) begin
      finish = 1'b1;
    end else if (dir_q == DIR_UP) begin
      if (phase_M == stop_q) begin
        case (mode_q)
          SWEEP_MODE_REPEAT_UP: next_phase = start_q;
          SWEEP_MODE_TRIANGLE: begin
            next_dir   = DIR_DOWN;
            next_phase = down_next;
          end
          default:              finish = 1'b1;
        endcase
      end else begin
        next_phase = up_next;
      end
    end else begin
      if (phase_M == start_q) begin
        next_dir   = DIR_UP;
        next_phase = up_next;
      end else begin
        next_phase = down_next;
      end
    end
  end

  assign reload     = launch || ((state == ST_RUN) && !stop && expire && !finish);
  assign reload_val = launch ? dwell_in_eff : dwell_q;

  dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (reload),
    .load_val (reload_val),
    .en       (state == ST_RUN),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mode_q       <= SWEEP_MODE_ONCE_UP;
      dir_q        <= DIR_UP;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      degen_q      <= 1'b0;
      phase_M      <= '0;
      signal_A     <= '0;
      signal_shape <= '0;
      upd          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      upd  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            mode_q       <= sweep_mode_e'(mode);
            start_q      <= m_start;
            stop_q       <= m_stop;
            step_q       <= m_step;
            dwell_q      <= dwell_in_eff;
            degen_q      <= (m_step == '0) || (m_start >= m_stop);
            dir_q        <= DIR_UP;
            phase_M      <= m_start;
            signal_A     <= amp_in;
            signal_shape <= shape_in;
            upd          <= 1'b1;
            busy         <= 1'b1;
            state        <= (sweep_mode_e'(mode) == SWEEP_MODE_HOLD) ? ST_HOLD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (expire) begin
            if (finish) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              phase_M <= next_phase;
              dir_q   <= next_dir;
              upd     <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
